// File: rtl/rv32i_instr_decoder_if.sv
// Decode bus between fetch/datapath and the RV32I main decoder.
// The master drives the instruction word; the slave returns the decoded view.
interface rv32i_instr_decoder_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] instr;
  logic            instrValid;
  logic            isALUreg, regWrite, isJAL, isJALR, isBranch;
  logic            isLUI, isAUIPC, isALUimm, isLoad, isStore;
  logic            isIllegal, illegalSeen;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm;

  modport master (
    output instr, instrValid,
    input  isALUreg, regWrite, isJAL, isJALR, isBranch, isLUI, isAUIPC,
           isALUimm, isLoad, isStore, isIllegal, illegalSeen,
           rd, rs1, rs2, funct3, funct7, imm
  );

  modport slave (
    input  instr, instrValid,
    output isALUreg, regWrite, isJAL, isJALR, isBranch, isLUI, isAUIPC,
           isALUimm, isLoad, isStore, isIllegal, illegalSeen,
           rd, rs1, rs2, funct3, funct7, imm
  );
endinterface

// File: rtl/rv32i_instr_decoder.sv
// RV32I main decoder: combinational class flags, fields and immediate,
// plus a sticky illegal-opcode status bit for debug.
module rv32i_instr_decoder #(
  parameter int XLEN = 32
) (
  input logic             clk,
  input logic             reset,
  rv32i_instr_decoder_if.slave dec
);
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [31:0]     ins;
  logic [XLEN-1:0] imm_d;
  logic            illegal_d;
  logic            illegal_seen_d, illegal_seen_q;

  assign ins = dec.instr;

  always_comb begin
    dec.isALUreg = 1'b0;
    dec.isALUimm = 1'b0;
    dec.isLoad   = 1'b0;
    dec.isStore  = 1'b0;
    dec.isBranch = 1'b0;
    dec.isJAL    = 1'b0;
    dec.isJALR   = 1'b0;
    dec.isLUI    = 1'b0;
    dec.isAUIPC  = 1'b0;
    illegal_d    = 1'b0;
    imm_d        = '0;
    // Full 7-bit match only; FENCE/SYSTEM fall through to illegal.
    unique case (ins[6:0])
      OP_REG:   dec.isALUreg = 1'b1;
      OP_IMM: begin
        dec.isALUimm = 1'b1;
        imm_d = {{20{ins[31]}}, ins[31:20]};
      end
      OP_LOAD: begin
        dec.isLoad = 1'b1;
        imm_d = {{20{ins[31]}}, ins[31:20]};
      end
      OP_JALR: begin
        dec.isJALR = 1'b1;
        imm_d = {{20{ins[31]}}, ins[31:20]};
      end
      OP_STORE: begin
        dec.isStore = 1'b1;
        imm_d = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      OP_BR: begin
        dec.isBranch = 1'b1;
        imm_d = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      OP_LUI: begin
        dec.isLUI = 1'b1;
        imm_d = {ins[31:12], 12'b0};
      end
      OP_AUIPC: begin
        dec.isAUIPC = 1'b1;
        imm_d = {ins[31:12], 12'b0};
      end
      OP_JAL: begin
        dec.isJAL = 1'b1;
        imm_d = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      default:  illegal_d = 1'b1;
    endcase
  end

  // rd is written by everything legal except branches and stores, even for x0.
  assign dec.regWrite  = ~illegal_d & ~dec.isBranch & ~dec.isStore;
  assign dec.isIllegal = illegal_d;
  assign dec.imm       = imm_d;
  assign dec.rd        = ins[11:7];
  assign dec.rs1       = ins[19:15];
  assign dec.rs2       = ins[24:20];
  assign dec.funct3    = ins[14:12];
  assign dec.funct7    = ins[31:25];

  always_comb begin
    illegal_seen_d = illegal_seen_q;
    if (dec.instrValid && illegal_d) illegal_seen_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) illegal_seen_q <= 1'b0;
    else       illegal_seen_q <= illegal_seen_d;
  end

  assign dec.illegalSeen = illegal_seen_q;
endmodule

// File: tb/tb_rv32i_instr_decoder.sv
// Self-checking bench for rv32i_instr_decoder: random instruction words
// against an arithmetic reference model, plus hand-computed anchor vectors.
module tb_rv32i_instr_decoder;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic started = 1'b0;
  logic exp_seen = 1'b0;

  always #5 clk = ~clk;

  rv32i_instr_decoder_if #(.XLEN(32)) bus ();
  rv32i_instr_decoder #(.XLEN(32)) dut (.clk(clk), .reset(reset), .dec(bus.slave));

  typedef struct {
    logic [9:0]  flags;  // ALUreg,regWrite,JAL,JALR,Branch,LUI,AUIPC,ALUimm,Load,Store
    logic        ill;
    logic [31:0] imm;
  } exp_t;

  function automatic longint bits(input logic [31:0] w, input int hi, input int lo);
    return longint'((w >> lo) & ((32'h1 << (hi - lo + 1)) - 1));
  endfunction

  function automatic longint sext(input longint v, input int width);
    return (v >= (64'sd1 <<< (width - 1))) ? v - (64'sd1 <<< width) : v;
  endfunction

  function automatic exp_t model(input logic [31:0] w);
    exp_t   e;
    longint v;
    e.flags = '0; e.ill = 1'b0; v = 0;
    case (w & 32'h7F)
      32'h33: e.flags = 10'b1100000000;
      32'h13: begin e.flags = 10'b0100000100; v = sext(bits(w, 31, 20), 12); end
      32'h03: begin e.flags = 10'b0100000010; v = sext(bits(w, 31, 20), 12); end
      32'h67: begin e.flags = 10'b0101000000; v = sext(bits(w, 31, 20), 12); end
      32'h23: begin
        e.flags = 10'b0000000001;
        v = sext(bits(w, 31, 25) * 32 + bits(w, 11, 7), 12);
      end
      32'h63: begin
        e.flags = 10'b0000100000;
        v = sext(bits(w, 31, 31) * 4096 + bits(w, 7, 7) * 2048 +
                 bits(w, 30, 25) * 32 + bits(w, 11, 8) * 2, 13);
      end
      32'h37: begin e.flags = 10'b0100010000; v = bits(w, 31, 12) * 4096; end
      32'h17: begin e.flags = 10'b0100001000; v = bits(w, 31, 12) * 4096; end
      32'h6F: begin
        e.flags = 10'b0110000000;
        v = sext(bits(w, 31, 31) * (1 << 20) + bits(w, 19, 12) * 4096 +
                 bits(w, 20, 20) * 2048 + bits(w, 30, 21) * 2, 21);
      end
      default: e.ill = 1'b1;
    endcase
    e.imm = v[31:0];
    return e;
  endfunction

  function automatic logic [9:0] dut_flags();
    return {bus.isALUreg, bus.regWrite, bus.isJAL, bus.isJALR, bus.isBranch,
            bus.isLUI, bus.isAUIPC, bus.isALUimm, bus.isLoad, bus.isStore};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s instr=%08h got=%0h expected=%0h", name, bus.instr, act, exp);
    end
  endtask

  // Sticky-status reference, sampled at the edge the DUT uses.
  always @(posedge clk) begin
    started <= 1'b1;
    if (reset) exp_seen <= 1'b0;
    else if (bus.instrValid && model(bus.instr).ill) exp_seen <= 1'b1;
  end

  // Every cycle: full comparison of the decoded view against the model.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] w;
    w = bus.instr;
    e = model(w);
    chk("flags",   {22'b0, dut_flags()}, {22'b0, e.flags});
    chk("illegal", {31'b0, bus.isIllegal}, {31'b0, e.ill});
    chk("imm",     bus.imm, e.imm);
    chk("fields",  {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, 7'b0},
                   {w[31:7], 7'b0});
    if (started) chk("illegalSeen", {31'b0, bus.illegalSeen}, {31'b0, exp_seen});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Anchor: both DUT and model must agree with the hand-derived value.
  task automatic lit(input string name, input logic [31:0] w, input logic [9:0] fl,
                     input logic [31:0] imm);
    exp_t e;
    bus.instr = w;
    #1;
    e = model(w);
    chk({name, "_flags"}, {22'b0, dut_flags()}, {22'b0, fl});
    chk({name, "_imm"}, bus.imm, imm);
    chk({name, "_model"}, {e.flags, e.imm[21:0]}, {fl, imm[21:0]});
  endtask

  initial begin
    logic [6:0] ops [11];
    logic [31:0] w;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h0F, 7'h73};
    reset = 1'b1; bus.instr = '0; bus.instrValid = 1'b0;
    step(); step();
    reset = 1'b0;

    // Illegal word without valid: flags clear, sticky stays low.
    step(); step();
    chk("ill_noval_isIllegal", {31'b0, bus.isIllegal}, 32'd1);
    chk("ill_noval_flags", {22'b0, dut_flags()}, 32'd0);
    chk("ill_noval_imm", bus.imm, 32'd0);
    chk("ill_noval_seen", {31'b0, bus.illegalSeen}, 32'd0);
    bus.instrValid = 1'b1;
    step();
    chk("ill_val_seen", {31'b0, bus.illegalSeen}, 32'd1);
    bus.instr = 32'h00500093;
    step(); step();
    chk("legal_hold_seen", {31'b0, bus.illegalSeen}, 32'd1);
    reset = 1'b1;
    step();
    chk("reset_clears_seen", {31'b0, bus.illegalSeen}, 32'd0);
    reset = 1'b0;
    step();
    // Reset wins against a valid illegal instruction at the same edge.
    reset = 1'b1; bus.instr = 32'h0000000F; bus.instrValid = 1'b1;
    step();
    chk("reset_wins_seen", {31'b0, bus.illegalSeen}, 32'd0);
    reset = 1'b0; bus.instrValid = 1'b0;

    lit("add",   32'h002081B3, 10'b1100000000, 32'h0);
    chk("add_rd", {27'b0, bus.rd}, 32'd3);
    chk("add_rs1", {27'b0, bus.rs1}, 32'd1);
    chk("add_rs2", {27'b0, bus.rs2}, 32'd2);
    lit("addi",  32'h00500093, 10'b0100000100, 32'h5);
    lit("lw",    32'h00812283, 10'b0100000010, 32'h8);
    chk("lw_funct3", {29'b0, bus.funct3}, 32'd2);
    lit("sw",    32'h00512623, 10'b0000000001, 32'hC);
    chk("sw_rs2", {27'b0, bus.rs2}, 32'd5);
    lit("beq",   32'hFE000EE3, 10'b0000100000, 32'hFFFFFFFC);
    lit("lui",   32'h123450B7, 10'b0100010000, 32'h12345000);
    lit("jal",   32'h008000EF, 10'b0110000000, 32'h8);
    lit("jalr",  32'h000080E7, 10'b0101000000, 32'h0);
    lit("auipc", 32'h00000097, 10'b0100001000, 32'h0);
    lit("fence", 32'h0FF0000F, 10'b0000000000, 32'h0);
    lit("addi_neg", 32'hFFF00093, 10'b0100000100, 32'hFFFFFFFF);
    lit("jal_neg",  32'hFFDFF0EF, 10'b0110000000, 32'hFFFFFFFC);
    step();

    // Random: mostly legal-opcode words with random payload, some fully random.
    for (int i = 0; i < 3000; i++) begin
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[6:0] = ops[$urandom_range(0, 10)];
      bus.instr      = w;
      bus.instrValid = ($urandom_range(0, 7) == 0);
      reset          = ($urandom_range(0, 63) == 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
